// File: rtl/counter_pkg.sv
// Shared constants and types for the free-running counter.
package counter_pkg;

    localparam int unsigned COUNTER_WIDTH_DEFAULT = 4;

    typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

    localparam count_t COUNTER_RESET_DEFAULT = '0;

endpackage : counter_pkg

// File: rtl/counter.sv
// Free-running WIDTH-bit up counter with asynchronous active-high reset to RESET_VAL.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = COUNTER_WIDTH_DEFAULT,
    parameter int unsigned RESET_VAL = 32'(COUNTER_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_next;

    // Carry out of the top bit is dropped, giving modulo-2^WIDTH wrap.
    assign count_next = count + WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= WIDTH'(RESET_VAL);
        end else begin
            count <= count_next;
        end
    end

`ifndef SYNTHESIS
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter: WIDTH=%0d outside 1..32", WIDTH);
    end

    if (64'(RESET_VAL) >= (64'd1 << WIDTH)) begin : g_bad_reset_val
        $error("counter: RESET_VAL=%0d does not fit in WIDTH=%0d", RESET_VAL, WIDTH);
    end

    logic [WIDTH-1:0] chk_prev;
    logic             chk_valid;

    // Reads of count here see the pre-edge value, so each edge compares against the previous one.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_valid <= 1'b0;
            chk_prev  <= WIDTH'(RESET_VAL);
        end else begin
            if (chk_valid) begin
                assert (!$isunknown(count))
                    else $error("counter: count is X/Z out of reset");
                assert (count == WIDTH'(chk_prev + WIDTH'(1)))
                    else $error("counter: count %0d did not follow %0d", count, chk_prev);
            end
            chk_valid <= 1'b1;
            chk_prev  <= count;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            assert (count == WIDTH'(RESET_VAL))
                else $error("counter: count %0d != RESET_VAL during reset", count);
        end
    end
`endif

endmodule : counter

// File: tb/tb_counter.sv
// Directed self-checking bench for counter: default 4-bit instance plus a WIDTH=3, RESET_VAL=5 instance.
module tb_counter;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic [2:0] count3;

    int checks;
    int failures;
    int n_changes;

    counter dut (
        .clk   (clk),
        .reset (reset),
        .count (count)
    );

    counter #(
        .WIDTH     (3),
        .RESET_VAL (5)
    ) dut3 (
        .clk   (clk),
        .reset (reset),
        .count (count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(count) n_changes++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_count;
        checks    = 0;
        failures  = 0;
        n_changes = 0;

        // Reset from t=0, released at t=10
        reset = 1'b1;
        #2;
        check("rst_t2", 32'(count), 32'd0);
        check("rst_t2_w3", 32'(count3), 32'd5);
        #4;
        check("rst_edge5", 32'(count), 32'd0);
        #4;
        reset = 1'b0;
        #4;
        check("release_t14", 32'(count), 32'd0);
        check("release_t14_w3", 32'(count3), 32'd5);

        edge_wait();
        check("edge15", 32'(count), 32'd1);
        check("edge15_w3", 32'(count3), 32'd6);
        edge_wait();
        check("edge25", 32'(count), 32'd2);
        check("edge25_w3", 32'(count3), 32'd7);
        edge_wait();
        check("edge35", 32'(count), 32'd3);
        check("edge35_w3_wrap", 32'(count3), 32'd0);
        edge_wait();
        check("edge45", 32'(count), 32'd4);
        check("edge45_w3", 32'(count3), 32'd1);

        // Free run to 100 edges after release
        exp_count = 4'd4;
        for (int i = 5; i <= 100; i++) begin
            edge_wait();
            exp_count = 4'((i) % 16);
            check("free_run", 32'(count), 32'(exp_count));
        end
        check("edge100", 32'(count), 32'd4);

        // Advance to 9, then pulse reset between edges
        for (int i = 0; i < 5; i++) edge_wait();
        check("at_nine", 32'(count), 32'd9);
        #2;
        reset = 1'b1;
        #1;
        check("mid_pulse_async", 32'(count), 32'd0);
        #1;
        reset = 1'b0;
        edge_wait();
        check("after_pulse", 32'(count), 32'd1);

        // Hold reset across 5 edges
        #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edge_wait();
            check("hold_reset", 32'(count), 32'd0);
            check("hold_reset_w3", 32'(count3), 32'd5);
        end
        #2;
        reset = 1'b0;
        edge_wait();
        check("after_hold", 32'(count), 32'd1);

        // Drive to 15, then one edge must wrap cleanly to 0
        for (int i = 0; i < 14; i++) edge_wait();
        check("at_fifteen", 32'(count), 32'd15);
        n_changes = 0;
        edge_wait();
        check("wrap_to_zero", 32'(count), 32'd0);
        check("wrap_single_change", 32'(n_changes), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_counter
